// File: rtl/udma_stream_unit_v2_if.sv
// Bus bundle for udma_stream_unit_v2: TX read channel, bypass and
// output streams, and the snooped spoof write bus.
interface udma_stream_unit_v2_if #(
    parameter int L2_AWIDTH_NOAL  = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int STREAM_ID_WIDTH = 2
);
    logic                       tx_ch_req_o;
    logic                       tx_ch_gnt_i;
    logic [L2_AWIDTH_NOAL-1:0]  tx_ch_addr_o;
    logic [1:0]                 tx_ch_datasize_o;
    logic                       tx_ch_valid_i;
    logic [DATA_WIDTH-1:0]      tx_ch_data_i;
    logic                       tx_ch_ready_o;

    logic [STREAM_ID_WIDTH-1:0] in_stream_dest_i;
    logic [DATA_WIDTH-1:0]      in_stream_data_i;
    logic [1:0]                 in_stream_datasize_i;
    logic                       in_stream_valid_i;
    logic                       in_stream_sot_i;
    logic                       in_stream_eot_i;
    logic                       in_stream_ready_o;

    logic [DATA_WIDTH-1:0]      out_stream_data_o;
    logic [1:0]                 out_stream_datasize_o;
    logic                       out_stream_valid_o;
    logic                       out_stream_sot_o;
    logic                       out_stream_eot_o;
    logic                       out_stream_ready_i;

    logic [L2_AWIDTH_NOAL-1:0]  spoof_addr_i;
    logic [STREAM_ID_WIDTH-1:0] spoof_dest_i;
    logic [1:0]                 spoof_datasize_i;
    logic                       spoof_req_i;
    logic                       spoof_gnt_i;

    modport master (
        output tx_ch_req_o, tx_ch_addr_o, tx_ch_datasize_o,
        input  tx_ch_gnt_i, tx_ch_valid_i, tx_ch_data_i,
        output tx_ch_ready_o,
        input  in_stream_dest_i, in_stream_data_i,
        input  in_stream_datasize_i, in_stream_valid_i,
        input  in_stream_sot_i, in_stream_eot_i,
        output in_stream_ready_o,
        output out_stream_data_o, out_stream_datasize_o,
        output out_stream_valid_o, out_stream_sot_o,
        output out_stream_eot_o,
        input  out_stream_ready_i,
        input  spoof_addr_i, spoof_dest_i, spoof_datasize_i,
        input  spoof_req_i, spoof_gnt_i
    );

    modport slave (
        input  tx_ch_req_o, tx_ch_addr_o, tx_ch_datasize_o,
        output tx_ch_gnt_i, tx_ch_valid_i, tx_ch_data_i,
        input  tx_ch_ready_o,
        output in_stream_dest_i, in_stream_data_i,
        output in_stream_datasize_i, in_stream_valid_i,
        output in_stream_sot_i, in_stream_eot_i,
        input  in_stream_ready_o,
        input  out_stream_data_o, out_stream_datasize_o,
        input  out_stream_valid_o, out_stream_sot_o,
        input  out_stream_eot_o,
        output out_stream_ready_i,
        output spoof_addr_i, spoof_dest_i, spoof_datasize_i,
        output spoof_req_i, spoof_gnt_i
    );
endinterface

// File: rtl/udma_stream_unit_v2.sv
// Stream-replay unit: re-reads snooped L2 writes in write order.
// Define UDMA_STREAM_JUMP_EN to enable the out-of-order jump queue.
module udma_stream_unit_v2 #(
    parameter int L2_AWIDTH_NOAL  = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int STREAM_ID_WIDTH = 2,
    parameter int INST_ID         = 0,
    parameter int FIFO_DEPTH      = 4,
    parameter int JUMP_DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_clr_i,
    udma_stream_unit_v2_if.master bus,
    output logic                  status_busy_o,
    output logic                  status_err_o
);
    localparam int AW = L2_AWIDTH_NOAL;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 2;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
        $error("FIFO_DEPTH must be a power of 2 >= 2");
    if (JUMP_DEPTH < 1 || (JUMP_DEPTH & (JUMP_DEPTH - 1)) != 0)
        $error("JUMP_DEPTH must be a power of 2 >= 1");

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]      size_q, size_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            sot_q, sot_d;
    logic            err_q, err_d;
    logic [FW-1:0]   fifo_rd_q, fifo_rd_d;
    logic [FW-1:0]   fifo_wr_q, fifo_wr_d;
    logic [FW:0]     fifo_cnt_q, fifo_cnt_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

    logic          w_acc, r_acc, busy, tx_req, tx_ready;
    logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic          rx_beat, rx_drop, adv, jump;
    logic [AW-1:0] inc;
    logic [CW-1:0] occ;

`ifdef UDMA_STREAM_JUMP_EN
    localparam int JW  = (JUMP_DEPTH > 1) ? $clog2(JUMP_DEPTH) : 1;
    localparam int JCW = $clog2(JUMP_DEPTH + 1);

    logic [AW-1:0]  jq_src_q [JUMP_DEPTH];
    logic [AW-1:0]  jq_dst_q [JUMP_DEPTH];
    logic [JW-1:0]  jq_head_q, jq_head_d;
    logic [JW-1:0]  jq_tail_q, jq_tail_d;
    logic [JCW-1:0] jq_cnt_q, jq_cnt_d;
    logic           jq_push, jq_push_ok, jq_pop, jq_full;

    function automatic logic [JW-1:0] jq_next(input logic [JW-1:0] p);
        return (p == JW'(JUMP_DEPTH - 1)) ? '0 : p + JW'(1);
    endfunction
`endif

    function automatic logic [AW-1:0] inc_of(input logic [1:0] s);
        unique case (s)
            2'd0:    return AW'(1);
            2'd1:    return AW'(2);
            default: return AW'(4);
        endcase
    endfunction

    always_comb begin
        w_acc      = bus.spoof_req_i & bus.spoof_gnt_i &
                     (bus.spoof_dest_i == STREAM_ID_WIDTH'(INST_ID));
        inc        = inc_of(size_q);
        busy       = (state_q != ST_IDLE);
        fifo_full  = (fifo_cnt_q == (FW+1)'(FIFO_DEPTH));
        fifo_empty = (fifo_cnt_q == '0);
        fifo_pop   = busy & ~fifo_empty & bus.out_stream_ready_i;
        tx_ready   = (discard_q != '0) | ~fifo_full | fifo_pop;
        rx_beat    = bus.tx_ch_valid_i & tx_ready;
        rx_drop    = rx_beat & (discard_q != '0);
        fifo_push  = rx_beat & ~rx_drop;
        occ        = out_cnt_q + CW'(fifo_cnt_q);
        tx_req     = (state_q == ST_RUN) & (occ < CW'(FIFO_DEPTH));
        r_acc      = tx_req & bus.tx_ch_gnt_i;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        size_d     = size_q;
        sot_d      = sot_q & ~fifo_pop;
        err_d      = err_q;
        out_cnt_d  = out_cnt_q + CW'(r_acc) - CW'(fifo_push);
        discard_d  = discard_q - CW'(rx_drop);
        fifo_rd_d  = fifo_rd_q + FW'(fifo_pop);
        fifo_wr_d  = fifo_wr_q + FW'(fifo_push);
        fifo_cnt_d = fifo_cnt_q + (FW+1)'(fifo_push)
                                - (FW+1)'(fifo_pop);
        adv        = 1'b0;
        jump       = 1'b0;
`ifdef UDMA_STREAM_JUMP_EN
        jq_head_d  = jq_head_q;
        jq_tail_d  = jq_tail_q;
        jq_cnt_d   = jq_cnt_q;
        jq_pop     = 1'b0;
        jq_full    = (jq_cnt_q == JCW'(JUMP_DEPTH));
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (w_acc) begin
                    wr_ptr_d = bus.spoof_addr_i;
                    rd_ptr_d = bus.spoof_addr_i;
                    size_d   = bus.spoof_datasize_i;
                    sot_d    = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_acc) begin
                    if (rd_ptr_q == wr_ptr_q && !w_acc) state_d = ST_WAIT;
                    else                                adv     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_acc) begin
                    adv     = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (busy && w_acc) begin
            wr_ptr_d = bus.spoof_addr_i;
            jump     = (bus.spoof_addr_i != wr_ptr_q + inc);
        end

`ifdef UDMA_STREAM_JUMP_EN
        // Caught up with the writer: the new write address is next.
        if (adv) begin
            if (w_acc && rd_ptr_q == wr_ptr_q) begin
                rd_ptr_d = bus.spoof_addr_i;
            end else if (jq_cnt_q != '0 &&
                         rd_ptr_q == jq_src_q[jq_head_q]) begin
                rd_ptr_d = jq_dst_q[jq_head_q];
                jq_pop   = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + inc;
            end
        end
        jq_push    = jump & ~(adv & (rd_ptr_q == wr_ptr_q));
        jq_push_ok = jq_push & (~jq_full | jq_pop);
        if (jq_push && !jq_push_ok) err_d = 1'b1;
        if (jq_push_ok) jq_tail_d = jq_next(jq_tail_q);
        if (jq_pop)     jq_head_d = jq_next(jq_head_q);
        jq_cnt_d = jq_cnt_q + JCW'(jq_push_ok) - JCW'(jq_pop);
`else
        if (adv)  rd_ptr_d = rd_ptr_q + inc;
        if (jump) err_d    = 1'b1;
`endif

        // In-flight reads become beats to drop after a clear.
        if (cmd_clr_i) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            size_d     = '0;
            sot_d      = 1'b0;
            err_d      = 1'b0;
            out_cnt_d  = '0;
            discard_d  = discard_q + out_cnt_q + CW'(r_acc)
                                   - CW'(rx_beat);
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
`ifdef UDMA_STREAM_JUMP_EN
            jq_head_d  = '0;
            jq_tail_d  = '0;
            jq_cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            size_q     <= '0;
            out_cnt_q  <= '0;
            discard_q  <= '0;
            sot_q      <= 1'b0;
            err_q      <= 1'b0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            size_q     <= size_d;
            out_cnt_q  <= out_cnt_d;
            discard_q  <= discard_d;
            sot_q      <= sot_d;
            err_q      <= err_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem_q[fifo_wr_q] <= bus.tx_ch_data_i;
    end

`ifdef UDMA_STREAM_JUMP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            jq_head_q <= '0;
            jq_tail_q <= '0;
            jq_cnt_q  <= '0;
        end else begin
            jq_head_q <= jq_head_d;
            jq_tail_q <= jq_tail_d;
            jq_cnt_q  <= jq_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (jq_push_ok && !cmd_clr_i) begin
            jq_src_q[jq_tail_q] <= wr_ptr_q;
            jq_dst_q[jq_tail_q] <= bus.spoof_addr_i;
        end
    end
`endif

    assign bus.tx_ch_req_o      = tx_req;
    assign bus.tx_ch_addr_o     = rd_ptr_q;
    assign bus.tx_ch_datasize_o = size_q;
    assign bus.tx_ch_ready_o    = tx_ready;

    assign bus.in_stream_ready_o = busy ? 1'b0 : bus.out_stream_ready_i;

    assign bus.out_stream_data_o =
        busy ? fifo_mem_q[fifo_rd_q] : bus.in_stream_data_i;
    assign bus.out_stream_datasize_o =
        busy ? size_q : bus.in_stream_datasize_i;
    assign bus.out_stream_valid_o =
        busy ? ~fifo_empty : bus.in_stream_valid_i;
    assign bus.out_stream_sot_o =
        busy ? sot_q : bus.in_stream_sot_i;
    assign bus.out_stream_eot_o =
        busy ? 1'b0 : bus.in_stream_eot_i;

    assign status_busy_o = busy;
    assign status_err_o  = err_q;
endmodule

// File: tb/tb_udma_stream_unit_v2.sv
// Directed bench for udma_stream_unit_v2 with an L2 responder model
// that returns 0xA500_0000 | addr for every granted read.
module tb_udma_stream_unit_v2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic busy, err;
    logic resp_en = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] pend[$];
    logic [15:0] rd_log[$];
    logic [31:0] beat_d[$];
    logic        beat_s[$];

    udma_stream_unit_v2_if bus();

    udma_stream_unit_v2 dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_clr_i     (clr),
        .bus           (bus),
        .status_busy_o (busy),
        .status_err_o  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_at(input int i);
        return (i < rd_log.size()) ? {16'h0, rd_log[i]} : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] bd_at(input int i);
        return (i < beat_d.size()) ? beat_d[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] bs_at(input int i);
        return (i < beat_s.size()) ? {31'h0, beat_s[i]} : 32'hDEAD_DEAD;
    endfunction

    task automatic tick();
        logic        r_hs, v_hs;
        logic [15:0] ra;
        @(negedge clk);
        r_hs = bus.tx_ch_req_o & bus.tx_ch_gnt_i;
        ra   = bus.tx_ch_addr_o;
        v_hs = bus.tx_ch_valid_i & bus.tx_ch_ready_o;
        if (bus.out_stream_valid_o & bus.out_stream_ready_i) begin
            beat_d.push_back(bus.out_stream_data_o);
            beat_s.push_back(bus.out_stream_sot_o);
        end
        @(posedge clk);
        #1;
        if (v_hs && pend.size() > 0) void'(pend.pop_front());
        if (r_hs) begin
            pend.push_back(ra);
            rd_log.push_back(ra);
        end
        bus.tx_ch_valid_i = resp_en && pend.size() > 0;
        bus.tx_ch_data_i  = bus.tx_ch_valid_i ?
                            (32'hA500_0000 | {16'h0, pend[0]}) : 32'h0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_w(input logic [15:0] a);
        bus.spoof_req_i      = 1'b1;
        bus.spoof_addr_i     = a;
        bus.spoof_datasize_i = 2'd2;
    endtask

    task automatic stop_w();
        bus.spoof_req_i = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        beat_d.delete();
        beat_s.delete();
    endtask

    initial begin
        bus.tx_ch_gnt_i          = 1'b1;
        bus.tx_ch_valid_i        = 1'b0;
        bus.tx_ch_data_i         = '0;
        bus.in_stream_dest_i     = '0;
        bus.in_stream_data_i     = '0;
        bus.in_stream_datasize_i = '0;
        bus.in_stream_valid_i    = 1'b0;
        bus.in_stream_sot_i      = 1'b0;
        bus.in_stream_eot_i      = 1'b0;
        bus.out_stream_ready_i   = 1'b1;
        bus.spoof_addr_i         = '0;
        bus.spoof_dest_i         = '0;
        bus.spoof_datasize_i     = '0;
        bus.spoof_req_i          = 1'b0;
        bus.spoof_gnt_i          = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and IDLE bypass
        chk("rst_req", {31'h0, bus.tx_ch_req_o}, 32'h0);
        chk("rst_addr", {16'h0, bus.tx_ch_addr_o}, 32'h0);
        chk("rst_size", {30'h0, bus.tx_ch_datasize_o}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_txrdy", {31'h0, bus.tx_ch_ready_o}, 32'h1);
        bus.in_stream_data_i     = 32'h1234_5678;
        bus.in_stream_valid_i    = 1'b1;
        bus.in_stream_sot_i      = 1'b1;
        bus.in_stream_eot_i      = 1'b1;
        bus.in_stream_datasize_i = 2'd3;
        #1;
        chk("byp_data", bus.out_stream_data_o, 32'h1234_5678);
        chk("byp_valid", {31'h0, bus.out_stream_valid_o}, 32'h1);
        chk("byp_sot", {31'h0, bus.out_stream_sot_o}, 32'h1);
        chk("byp_eot", {31'h0, bus.out_stream_eot_o}, 32'h1);
        chk("byp_size", {30'h0, bus.out_stream_datasize_o}, 32'h3);
        chk("byp_rdy1", {31'h0, bus.in_stream_ready_o}, 32'h1);
        bus.out_stream_ready_i = 1'b0;
        #1;
        chk("byp_rdy0", {31'h0, bus.in_stream_ready_o}, 32'h0);
        bus.out_stream_ready_i   = 1'b1;
        bus.in_stream_valid_i    = 1'b0;
        bus.in_stream_sot_i      = 1'b0;
        bus.in_stream_eot_i      = 1'b0;
        bus.in_stream_datasize_i = 2'd0;

        // Contiguous writes
        clear_logs();
        set_w(16'h0100);
        tick();
        chk("c_req", {31'h0, bus.tx_ch_req_o}, 32'h1);
        chk("c_addr", {16'h0, bus.tx_ch_addr_o}, 32'h100);
        chk("c_dsize", {30'h0, bus.tx_ch_datasize_o}, 32'h2);
        chk("c_busy", {31'h0, busy}, 32'h1);
        set_w(16'h0104);
        tick();
        chk("c_addr2", {16'h0, bus.tx_ch_addr_o}, 32'h104);
        set_w(16'h0108);
        tick();
        stop_w();
        ticks(8);
        chk("c_nrd", rd_log.size(), 3);
        chk("c_rd0", rd_at(0), 32'h100);
        chk("c_rd1", rd_at(1), 32'h104);
        chk("c_rd2", rd_at(2), 32'h108);
        chk("c_wait_req", {31'h0, bus.tx_ch_req_o}, 32'h0);
        chk("c_wait_busy", {31'h0, busy}, 32'h1);
        chk("c_nbeat", beat_d.size(), 3);
        chk("c_d0", bd_at(0), 32'hA500_0100);
        chk("c_d1", bd_at(1), 32'hA500_0104);
        chk("c_d2", bd_at(2), 32'hA500_0108);
        chk("c_s0", bs_at(0), 32'h1);
        chk("c_s1", bs_at(1), 32'h0);
        chk("c_s2", bs_at(2), 32'h0);
        chk("c_osize", {30'h0, bus.out_stream_datasize_o}, 32'h2);
        chk("c_oeot", {31'h0, bus.out_stream_eot_o}, 32'h0);
        chk("c_inrdy", {31'h0, bus.in_stream_ready_o}, 32'h0);
        chk("c_err", {31'h0, err}, 32'h0);
        do_clear();
        chk("c_clr_busy", {31'h0, busy}, 32'h0);
        ticks(4);

        // Jump
        clear_logs();
        set_w(16'h0100);
        tick();
        set_w(16'h0104);
        tick();
        set_w(16'h0200);
        tick();
`ifdef UDMA_STREAM_JUMP_EN
        chk("j_err", {31'h0, err}, 32'h0);
`else
        chk("j_err", {31'h0, err}, 32'h1);
`endif
        set_w(16'h0204);
        tick();
        stop_w();
        ticks(8);
        chk("j_rd0", rd_at(0), 32'h100);
        chk("j_rd1", rd_at(1), 32'h104);
`ifdef UDMA_STREAM_JUMP_EN
        chk("j_rd2", rd_at(2), 32'h200);
        chk("j_rd3", rd_at(3), 32'h204);
        chk("j_nrd", rd_log.size(), 4);
        chk("j_nbeat", beat_d.size(), 4);
        chk("j_d3", bd_at(3), 32'hA500_0204);
        chk("j_err2", {31'h0, err}, 32'h0);
`else
        chk("j_rd2", rd_at(2), 32'h108);
        chk("j_rd3", rd_at(3), 32'h10C);
        chk("j_err2", {31'h0, err}, 32'h1);
`endif
        do_clear();
        chk("j_clr_err", {31'h0, err}, 32'h0);
        chk("j_clr_busy", {31'h0, busy}, 32'h0);
        ticks(8);

        // Jump queue overflow with reads stalled
        bus.tx_ch_gnt_i = 1'b0;
        set_w(16'h0010);
        tick();
        chk("o_err0", {31'h0, err}, 32'h0);
        set_w(16'h0040);
        tick();
`ifdef UDMA_STREAM_JUMP_EN
        chk("o_err1", {31'h0, err}, 32'h0);
        set_w(16'h0080);
        tick();
        chk("o_err2", {31'h0, err}, 32'h0);
        set_w(16'h00C0);
        tick();
        chk("o_err3", {31'h0, err}, 32'h1);
`else
        chk("o_err1", {31'h0, err}, 32'h1);
`endif
        stop_w();
        chk("o_addr", {16'h0, bus.tx_ch_addr_o}, 32'h10);
        do_clear();
        chk("o_clr_err", {31'h0, err}, 32'h0);
        ticks(2);

        // Output backpressure
        clear_logs();
        bus.out_stream_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_w(16'h0300 + 16'(4 * i));
            tick();
        end
        stop_w();
        bus.tx_ch_gnt_i = 1'b1;
        ticks(20);
        chk("b_grants", rd_log.size(), 4);
        chk("b_req", {31'h0, bus.tx_ch_req_o}, 32'h0);
        chk("b_txrdy", {31'h0, bus.tx_ch_ready_o}, 32'h0);
        chk("b_oval", {31'h0, bus.out_stream_valid_o}, 32'h1);
        chk("b_odata", bus.out_stream_data_o, 32'hA500_0300);
        chk("b_osot", {31'h0, bus.out_stream_sot_o}, 32'h1);
        bus.out_stream_ready_i = 1'b1;
        ticks(15);
        chk("b_nrd", rd_log.size(), 7);
        chk("b_nbeat", beat_d.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("b_d%0d", i), bd_at(i),
                32'hA500_0300 + 32'(4 * i));
            chk($sformatf("b_s%0d", i), bs_at(i), (i == 0) ? 32'h1 : 32'h0);
        end
        do_clear();
        ticks(4);

        // Address wrap
        clear_logs();
        set_w(16'hFFFC);
        tick();
        set_w(16'h0000);
        tick();
        stop_w();
        ticks(6);
        chk("w_err", {31'h0, err}, 32'h0);
        chk("w_nrd", rd_log.size(), 2);
        chk("w_rd0", rd_at(0), 32'hFFFC);
        chk("w_rd1", rd_at(1), 32'h0);
        chk("w_d0", bd_at(0), 32'hA500_FFFC);
        chk("w_d1", bd_at(1), 32'hA500_0000);
        do_clear();
        ticks(4);

        // Clear with two reads in flight
        clear_logs();
        resp_en = 1'b0;
        set_w(16'h0500);
        tick();
        set_w(16'h0504);
        tick();
        stop_w();
        ticks(2);
        chk("k_nrd", rd_log.size(), 2);
        do_clear();
        chk("k_busy", {31'h0, busy}, 32'h0);
        chk("k_req", {31'h0, bus.tx_ch_req_o}, 32'h0);
        bus.in_stream_data_i     = 32'h5555_AAAA;
        bus.in_stream_valid_i    = 1'b1;
        bus.in_stream_eot_i      = 1'b1;
        bus.in_stream_datasize_i = 2'd1;
        #1;
        chk("k_byp_data", bus.out_stream_data_o, 32'h5555_AAAA);
        chk("k_byp_val", {31'h0, bus.out_stream_valid_o}, 32'h1);
        chk("k_byp_eot", {31'h0, bus.out_stream_eot_o}, 32'h1);
        chk("k_byp_size", {30'h0, bus.out_stream_datasize_o}, 32'h1);
        chk("k_byp_rdy", {31'h0, bus.in_stream_ready_o}, 32'h1);
        bus.in_stream_valid_i    = 1'b0;
        bus.in_stream_eot_i      = 1'b0;
        bus.in_stream_datasize_i = 2'd0;
        beat_d.delete();
        beat_s.delete();
        set_w(16'h0600);
        tick();
        stop_w();
        ticks(2);
        resp_en = 1'b1;
        ticks(8);
        chk("k_nbeat", beat_d.size(), 1);
        chk("k_d0", bd_at(0), 32'hA500_0600);
        chk("k_s0", bs_at(0), 32'h1);
        chk("k_pend", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
